// File: rtl/ConvLoopParam.sv
// Shared types and arithmetic helpers for the convolution output path.
package ConvLoopParam;

  // Drain sequencing of the output write-back stage.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } wb_state_t;

  // Signed add clamped to a res-bit two's-complement range (res <= 31).
  // Operands arrive sign-extended to 32 bits so the raw sum cannot wrap.
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int                 res
  );
    logic signed [31:0] sum;
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    sum   = a + b;
    max_v = (32'sd1 <<< (res - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (res - 1));
    if (sum > max_v) return max_v;
    if (sum < min_v) return min_v;
    return sum;
  endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// Single-clock FIFO with occupancy count and same-cycle push/pop.
module wb_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 160
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage write; holds payload only, validity lives in cnt.
  // NOTE: the data array has no reset -- empty/count qualify every read, so
  // clearing it would only cost a reset net fan-out on every storage bit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is 2^AW.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/conv_out_writeback.sv
// Convolution output write-back: bias add, saturate, optional ReLU, buffer,
// and write to the output BRAM with a tile drain handshake.
module conv_out_writeback
  import ConvLoopParam::*;
#(
  parameter int RES        = 16,
  parameter int LANES      = 8,
  parameter int POF        = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [LANES*RES-1:0]    in_data,
  input  logic                    tile_done_in,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic                    relu_en,
  input  logic                    bias_we,
  input  logic [$clog2(POF)-1:0]  bias_idx,
  input  logic [RES-1:0]          bias_val,
  input  logic                    clr_err,
  output logic                    mem_req,
  input  logic                    mem_gnt,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANES*RES-1:0]    mem_wdata,
  output logic                    busy,
  output logic                    drain_done,
  output logic                    err_overflow
);

  localparam int DW = LANES * RES;
  localparam int FW = ADDR_W + DW;
  localparam int IW = $clog2(POF);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [IW-1:0]     of_idx;
  logic [RES-1:0]    bias_q [POF];
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [DW-1:0]     s1_data;
  logic [DW-1:0]     s1_data_d;
  logic [FW-1:0]     fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              fifo_push;
  logic              pop;
  logic [CW-1:0]     occ;
  logic              drop;
  logic              accept;
  wb_state_t         state;
  wb_state_t         state_d;

  // Occupancy counts the stage-1 word too, so a word is only refused when
  // every slot it could eventually need is already spoken for.
  assign pop       = mem_req && mem_gnt;
  assign occ       = fifo_count + CW'(s1_valid);
  assign drop      = in_valid && (occ == CW'(FIFO_DEPTH)) && !pop;
  assign accept    = in_valid && !drop;
  assign fifo_push = s1_valid && (!fifo_full || pop);

  assign mem_req   = !fifo_empty;
  assign mem_addr  = fifo_empty ? '0 : fifo_rdata[FW-1:DW];
  assign mem_wdata = fifo_empty ? '0 : fifo_rdata[DW-1:0];
  assign busy      = s1_valid || !fifo_empty || (state != RUN);

  // Per-lane bias add with saturation, then optional ReLU clamp.
  // NOTE: every variable written here gets a default before any branch so
  // no path leaves it holding a value, which would infer a latch.
  always_comb begin : lane_math
    logic [RES-1:0] lane_res;
    s1_data_d = '0;
    lane_res  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_res = RES'(sat_add(32'(signed'(in_data[i*RES +: RES])),
                              32'(signed'(bias_q[of_idx])), RES));
      if (relu_en && lane_res[RES-1]) lane_res = '0;
      s1_data_d[i*RES +: RES] = lane_res;
    end
  end

  // Stage-1 register: captures processed word and wrapped target address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr <= base_addr + in_addr;
        s1_data <= s1_data_d;
      end
    end
  end

  // Feature-map index advances on every strobe, dropped or not, so words
  // after an overflow keep their bias alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      of_idx <= '0;
    end else if (state == DONE) begin
      of_idx <= '0;
    end else if (in_valid) begin
      of_idx <= (of_idx == IW'(POF - 1)) ? '0 : of_idx + IW'(1);
    end
  end

  // Bias table; a same-cycle read of the written entry sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < POF; i++) bias_q[i] <= '0;
    end else if (bias_we) begin
      bias_q[bias_idx] <= bias_val;
    end
  end

  // Sticky overflow flag; clearing wins over a simultaneous drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_overflow <= 1'b0;
    else if (clr_err) err_overflow <= 1'b0;
    else if (drop)    err_overflow <= 1'b1;
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_d;
  end

  // Drain FSM next state; DONE lasts one cycle and produces the pulse.
  always_comb begin
    state_d    = state;
    drain_done = 1'b0;
    case (state)
      RUN:     if (tile_done_in) state_d = DRAIN;
      DRAIN:   if (!s1_valid && fifo_empty) state_d = DONE;
      DONE: begin
        drain_done = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  wb_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({s1_addr, s1_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
